imem_prog_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_prog_loader_if.sv | 29 ++
 rtl/loader_xor_acc.sv | 25 ++
 rtl/imem_prog_loader.sv | 142 ++++++++++++++
 tb/tb_imem_prog_loader.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The checksum is defined here so that the loader and any host tooling agree on it.
package imem_loader_pkg;

  localparam int MEM_BYTES = 128;
  localparam int ADDR_W    = 7;
  localparam int HDR_BYTES = 2;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    COUNT,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_e;

  // Checksum: XOR of every payload byte, seeded with zero at each Start.
  localparam logic [7:0] CHK_SEED = 8'h00;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_prog_loader_if.sv
// Byte stream in, instruction-memory write port and CPU control out.
// slave = loader side, master = host/memory/datapath side.
interface imem_prog_loader_if #(
  parameter int ADDR_W = 7,
  parameter int PC_W   = 16
);
  logic              Start;
  logic [7:0]        ByteIn;
  logic              ByteValid;
  logic              ByteReady;
  logic              MemWrite;
  logic [ADDR_W-1:0] MemAddr;
  logic [7:0]        MemData;
  logic              CpuHold;
  logic              PcLoad;
  logic [PC_W-1:0]   PcValue;
  logic              Done;
  logic              Error;

  modport slave (
    input  Start, ByteIn, ByteValid,
    output ByteReady, MemWrite, MemAddr, MemData, CpuHold, PcLoad, PcValue, Done, Error
  );

  modport master (
    output Start, ByteIn, ByteValid,
    input  ByteReady, MemWrite, MemAddr, MemData, CpuHold, PcLoad, PcValue, Done, Error
  );
endinterface

// File: rtl/loader_xor_acc.sv
// 8-bit running checksum with synchronous clear and enable; result visible the cycle after en_i.
// Clear has priority over enable.
module loader_xor_acc (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] din_i,
  output logic [7:0] acc_o
);
  import imem_loader_pkg::*;

  logic [7:0] acc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      acc_q <= CHK_SEED;
    end else if (en_i) begin
      acc_q <= chk_update(acc_q, din_i);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/imem_prog_loader.sv
// Loads a byte-stream program image into instruction memory (1-cycle registered write per byte),
// stalling the CPU throughout; ByteReady is asserted only while a header/payload/checksum byte is expected.
module imem_prog_loader #(
  parameter int MEM_BYTES = imem_loader_pkg::MEM_BYTES,
  parameter int ADDR_W    = imem_loader_pkg::ADDR_W,
  parameter int PC_W      = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  imem_prog_loader_if.slave   bus
);
  import imem_loader_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [8:0]        rem_q, rem_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic [PC_W-1:0]   pc_value_q, pc_value_d;

  logic              byte_rdy;
  logic              xfer;
  logic              chk_clr;
  logic              chk_en;
  logic [7:0]        chk_acc;
  logic [9:0]        end_addr;

  assign byte_rdy = (state_q == ADDR) || (state_q == COUNT) ||
                    (state_q == DATA) || (state_q == CHECK);
  assign xfer     = bus.ByteValid && byte_rdy;
  // Wide enough that LoadAddr + 2*255 can never wrap.
  assign end_addr = 10'(base_q) + {1'b0, bus.ByteIn, 1'b0};

  loader_xor_acc u_chk (
    .clk_i (Clock),
    .rst_i (Reset),
    .clr_i (chk_clr),
    .en_i  (chk_en),
    .din_i (bus.ByteIn),
    .acc_o (chk_acc)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    pc_value_d  = pc_value_q;
    chk_clr     = 1'b0;
    chk_en      = 1'b0;
    case (state_q)
      IDLE, ERR: begin
        if (bus.Start) begin
          state_d = ADDR;
          chk_clr = 1'b1;
        end
      end
      ADDR: begin
        if (xfer) begin
          if (bus.ByteIn[0] || ({1'b0, bus.ByteIn} >= 9'(MEM_BYTES))) begin
            state_d = ERR;
          end else begin
            base_d  = bus.ByteIn[ADDR_W-1:0];
            ptr_d   = bus.ByteIn[ADDR_W-1:0];
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        if (xfer) begin
          if ((bus.ByteIn == 8'h00) || (end_addr > 10'(MEM_BYTES))) begin
            state_d = ERR;
          end else begin
            rem_d   = {bus.ByteIn, 1'b0};
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          mem_write_d = 1'b1;
          mem_addr_d  = ptr_q;
          mem_data_d  = bus.ByteIn;
          ptr_d       = ptr_q + 1'b1;
          rem_d       = rem_q - 9'd1;
          chk_en      = 1'b1;
          if (rem_q == 9'd1) state_d = CHECK;
        end
      end
      CHECK: begin
        if (xfer) begin
          if (bus.ByteIn == chk_acc) begin
            state_d    = DONE;
            pc_value_d = PC_W'(base_q);
          end else begin
            state_d = ERR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      ptr_q       <= '0;
      rem_q       <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      pc_value_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      pc_value_q  <= pc_value_d;
    end
  end

  assign bus.ByteReady = byte_rdy;
  assign bus.MemWrite  = mem_write_q;
  assign bus.MemAddr   = mem_addr_q;
  assign bus.MemData   = mem_data_q;
  assign bus.CpuHold   = (state_q != IDLE);
  assign bus.PcLoad    = (state_q == DONE);
  assign bus.Done      = (state_q == DONE);
  assign bus.PcValue   = pc_value_q;
  assign bus.Error     = (state_q == ERR);

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed bench for imem_prog_loader: table of whole-stream scenarios plus
// hand-written reset-mid-load and Start-during-DATA sequences.
module tb_imem_prog_loader;

  typedef struct packed {
    logic [63:0] s;     // stream bytes, first byte in the top octet
    logic [3:0]  len;
    logic [3:0]  gap;
    logic        err;
    logic [3:0]  nwr;
    logic [7:0]  base;
  } vec_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pcl_n  = 0;
  logic [6:0] wr_a[$];
  logic [7:0] wr_d[$];
  vec_t vecs[8];

  imem_prog_loader_if #(.ADDR_W(7), .PC_W(16)) bus ();

  imem_prog_loader #(.MEM_BYTES(128), .ADDR_W(7), .PC_W(16)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (bus.MemWrite) begin
      wr_a.push_back(bus.MemAddr);
      wr_d.push_back(bus.MemData);
    end
    if (bus.PcLoad) pcl_n++;
  end

  function automatic logic [7:0] byte_at(input logic [63:0] s, input int i);
    return s[63-8*i -: 8];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input string nm);
    bit acc = 0;
    int t = 0;
    bus.ByteIn    = b;
    bus.ByteValid = 1'b1;
    while (!acc && t < 50) begin
      @(negedge Clock);
      if (bus.ByteReady) acc = 1;
      cyc();
      t++;
    end
    bus.ByteValid = 1'b0;
    if (!acc) begin
      errors++;
      $display("FAIL %s byte %0h not accepted within 50 cycles", nm, b);
    end
  endtask

  task automatic run_vec(input vec_t v, input int start_at, input string nm);
    int w0 = wr_a.size();
    int p0 = pcl_n;
    int drop = 0;
    bus.Start = 1'b1;
    cyc();
    bus.Start = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      if (i == start_at) begin
        bus.Start = 1'b1;
        cyc();
        cyc();
        bus.Start = 1'b0;
        @(negedge Clock);
        chk({nm, "_mid_start_rdy"}, bus.ByteReady, 1);
        chk({nm, "_mid_start_hold"}, bus.CpuHold, 1);
        cyc();
      end
      for (int g = 0; g < int'(v.gap); g++) begin
        @(negedge Clock);
        if (!bus.ByteReady) drop++;
        cyc();
      end
      send_byte(byte_at(v.s, i), nm);
    end
    if (v.gap != 0) chk({nm, "_rdy_drop_in_gap"}, drop, 0);
    @(negedge Clock);
    if (v.err) begin
      chk({nm, "_error"}, bus.Error, 1);
      chk({nm, "_hold_err"}, bus.CpuHold, 1);
      chk({nm, "_rdy_err"}, bus.ByteReady, 0);
    end else begin
      chk({nm, "_pcload"}, bus.PcLoad, 1);
      chk({nm, "_done"}, bus.Done, 1);
      chk({nm, "_pcvalue"}, bus.PcValue, {24'h0, v.base});
      chk({nm, "_hold_done"}, bus.CpuHold, 1);
      chk({nm, "_error_clr"}, bus.Error, 0);
      @(negedge Clock);
      chk({nm, "_hold_fall"}, bus.CpuHold, 0);
      chk({nm, "_pcload_pulse"}, bus.PcLoad, 0);
    end
    repeat (3) cyc();
    chk({nm, "_nwrites"}, wr_a.size() - w0, v.nwr);
    for (int k = 0; k < int'(v.nwr); k++) begin
      if (w0 + k < wr_a.size()) begin
        chk($sformatf("%s_waddr%0d", nm, k), {25'h0, wr_a[w0+k]}, 32'(v.base) + 32'(k));
        chk($sformatf("%s_wdata%0d", nm, k), {24'h0, wr_d[w0+k]}, {24'h0, byte_at(v.s, 2 + k)});
      end
    end
    chk({nm, "_pcload_cnt"}, pcl_n - p0, v.err ? 0 : 1);
  endtask

  initial begin
    int w0;
    vecs[0] = '{s: 64'h0A02_1234_5678_0800, len: 7, gap: 0, err: 0, nwr: 4, base: 8'h0A};
    vecs[1] = '{s: 64'h0A02_1234_5678_0800, len: 7, gap: 3, err: 0, nwr: 4, base: 8'h0A};
    vecs[2] = '{s: 64'h0A02_1234_5678_0900, len: 7, gap: 0, err: 1, nwr: 4, base: 8'h0A};
    vecs[3] = '{s: 64'h0A02_1234_5678_0800, len: 7, gap: 0, err: 0, nwr: 4, base: 8'h0A};
    vecs[4] = '{s: 64'h0B00_0000_0000_0000, len: 1, gap: 0, err: 1, nwr: 0, base: 8'h0B};
    vecs[5] = '{s: 64'h7E02_0000_0000_0000, len: 2, gap: 0, err: 1, nwr: 0, base: 8'h7E};
    vecs[6] = '{s: 64'h7C02_AABB_CCDD_0000, len: 7, gap: 0, err: 0, nwr: 4, base: 8'h7C};
    vecs[7] = '{s: 64'h0000_0000_0000_0000, len: 2, gap: 0, err: 1, nwr: 0, base: 8'h00};

    bus.Start = 1'b0;
    bus.ByteIn = 8'h00;
    bus.ByteValid = 1'b0;
    repeat (2) cyc();
    @(negedge Clock);
    chk("rst_bytrdy", bus.ByteReady, 0);
    chk("rst_memwrite", bus.MemWrite, 0);
    chk("rst_cpuhold", bus.CpuHold, 0);
    chk("rst_pcload", bus.PcLoad, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_error", bus.Error, 0);
    chk("rst_pcvalue", bus.PcValue, 0);
    Reset = 1'b0;
    cyc();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], -1, $sformatf("v%0d", i));

    // Reset after two payload bytes, with the next byte already offered.
    bus.Start = 1'b1;
    cyc();
    bus.Start = 1'b0;
    send_byte(8'h0A, "rstmid");
    send_byte(8'h02, "rstmid");
    send_byte(8'h12, "rstmid");
    send_byte(8'h34, "rstmid");
    bus.ByteIn = 8'h56;
    bus.ByteValid = 1'b1;
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    @(negedge Clock);
    chk("rstmid_memwrite", bus.MemWrite, 0);
    chk("rstmid_bytrdy", bus.ByteReady, 0);
    chk("rstmid_cpuhold", bus.CpuHold, 0);
    chk("rstmid_memaddr", bus.MemAddr, 0);
    chk("rstmid_memdata", bus.MemData, 0);
    chk("rstmid_pcvalue", bus.PcValue, 0);
    chk("rstmid_error", bus.Error, 0);
    w0 = wr_a.size();
    repeat (3) cyc();
    @(negedge Clock);
    chk("rstmid_ignored_writes", wr_a.size() - w0, 0);
    chk("rstmid_still_idle_rdy", bus.ByteReady, 0);
    bus.ByteValid = 1'b0;
    cyc();
    run_vec(vecs[0], -1, "rstmid_restart");

    // Start pulsed after the first payload byte must change nothing.
    run_vec(vecs[0], 3, "midstart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end

endmodule
